// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the sprite renderers and the VGA pins.
// The master drives it; renderers and the output stage take the slave view.
interface vga_timing_gen_if;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs_n;
  logic       vs_n;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output DrawX,
    output DrawY,
    output blank,
    output hs_n,
    output vs_n,
    output frame_start,
    output frame_count
  );

  modport slave (
    input DrawX,
    input DrawY,
    input blank,
    input hs_n,
    input vs_n,
    input frame_start,
    input frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel coordinates, display enable, delayed syncs,
// frame-start pulse and frame counter, all in the vga_clk domain.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
  end
  if (PIPE_DELAY > 4) begin : g_bad_delay
    $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
  end

  localparam logic [9:0]  HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VLast   = 10'(V_TOTAL - 1);
  localparam logic [10:0] HVis    = 11'(H_VISIBLE);
  localparam logic [10:0] VVis    = 11'(V_VISIBLE);
  localparam logic [10:0] HsStart = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HsEnd   = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VsStart = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] hc_q, hc_d;
  logic [9:0] vc_q, vc_d;
  logic       line_end, frame_end;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q;
  logic [7:0] fc_q;
  logic       hs_out, vs_out;

  // Decode the next counter values so the registered flags line up with DrawX/DrawY.
  always_comb begin
    line_end  = (hc_q == HLast);
    frame_end = line_end && (vc_q == VLast);
    hc_d      = line_end ? 10'd0 : hc_q + 10'd1;
    vc_d      = vc_q;
    if (line_end) begin
      vc_d = frame_end ? 10'd0 : vc_q + 10'd1;
    end
    blank_d = ({1'b0, hc_d} < HVis) && ({1'b0, vc_d} < VVis);
    hs_d    = !(({1'b0, hc_d} >= HsStart) && ({1'b0, hc_d} < HsEnd));
    vs_d    = !(({1'b0, vc_d} >= VsStart) && ({1'b0, vc_d} < VsEnd));
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_q    <= 10'd0;
      vc_q    <= 10'd0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= frame_end;
      fc_q    <= fc_q + {7'd0, frame_end};
    end
  end

  // Syncs trail the coordinates to match the renderers' registered RGB path.
  if (PIPE_DELAY == 0) begin : g_no_delay
    assign hs_out = hs_q;
    assign vs_out = vs_q;
  end else begin : g_delay
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;

    always_comb begin
      hs_pipe_d    = hs_pipe_q << 1;
      hs_pipe_d[0] = hs_q;
      vs_pipe_d    = vs_pipe_q << 1;
      vs_pipe_d[0] = vs_q;
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
        hs_pipe_q <= '1;
        vs_pipe_q <= '1;
      end else begin
        hs_pipe_q <= hs_pipe_d;
        vs_pipe_q <= vs_pipe_d;
      end
    end

    assign hs_out = hs_pipe_q[PIPE_DELAY-1];
    assign vs_out = vs_pipe_q[PIPE_DELAY-1];
  end

  assign vga.DrawX       = hc_q;
  assign vga.DrawY       = vc_q;
  assign vga.blank       = blank_q;
  assign vga.hs_n        = hs_out;
  assign vga.vs_n        = vs_out;
  assign vga.frame_start = fs_q;
  assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three builds (PIPE_DELAY 0/1/4) on a reduced raster, checked
// against an arithmetic model of raster position as a function of edges since reset.
module tb_vga_timing_gen;
  localparam int HV = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VV = 6, VFP = 1, VS = 2, VBP = 1;
  localparam int HT = HV + HFP + HS + HBP;
  localparam int VT = VV + VFP + VS + VBP;
  localparam int F  = HT * VT;

  logic   vga_clk = 1'b0;
  logic   reset_n = 1'b1;
  int     n_tests = 0;
  int     n_fail  = 0;
  longint t       = 0;  // rising edges since reset released

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen_if vif0 ();
  vga_timing_gen_if vif1 ();
  vga_timing_gen_if vif4 ();

  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_VISIBLE(VV),
                   .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIPE_DELAY(0))
    u_dut0 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vif0));
  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_VISIBLE(VV),
                   .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIPE_DELAY(1))
    u_dut1 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vif1));
  vga_timing_gen #(.H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP), .V_VISIBLE(VV),
                   .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .PIPE_DELAY(4))
    u_dut4 (.vga_clk(vga_clk), .reset_n(reset_n), .vga(vif4));

  logic [9:0] dx [3];
  logic [9:0] dy [3];
  logic       bl [3];
  logic       hs [3];
  logic       vs [3];
  logic       fs [3];
  logic [7:0] fc [3];

  assign dx[0] = vif0.DrawX;       assign dx[1] = vif1.DrawX;       assign dx[2] = vif4.DrawX;
  assign dy[0] = vif0.DrawY;       assign dy[1] = vif1.DrawY;       assign dy[2] = vif4.DrawY;
  assign bl[0] = vif0.blank;       assign bl[1] = vif1.blank;       assign bl[2] = vif4.blank;
  assign hs[0] = vif0.hs_n;        assign hs[1] = vif1.hs_n;        assign hs[2] = vif4.hs_n;
  assign vs[0] = vif0.vs_n;        assign vs[1] = vif1.vs_n;        assign vs[2] = vif4.vs_n;
  assign fs[0] = vif0.frame_start; assign fs[1] = vif1.frame_start; assign fs[2] = vif4.frame_start;
  assign fc[0] = vif0.frame_count; assign fc[1] = vif1.frame_count; assign fc[2] = vif4.frame_count;

  // ---------------- reference model ----------------
  function automatic int dly(int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic int mx(longint tt);
    return int'((tt % F) % HT);
  endfunction

  function automatic int my(longint tt);
    return int'((tt % F) / HT);
  endfunction

  function automatic logic m_blank(longint tt);
    if (tt <= 0) return 1'b0;
    return (mx(tt) < HV) && (my(tt) < VV);
  endfunction

  function automatic logic m_hs(longint tt, int d);
    longint k = tt - d;
    if (k <= 0) return 1'b1;
    return !((mx(k) >= HV + HFP) && (mx(k) < HV + HFP + HS));
  endfunction

  function automatic logic m_vs(longint tt, int d);
    longint k = tt - d;
    if (k <= 0) return 1'b1;
    return !((my(k) >= VV + VFP) && (my(k) < VV + VFP + VS));
  endfunction

  function automatic logic m_fs(longint tt);
    return (tt > 0) && ((tt % F) == 0);
  endfunction

  function automatic logic [7:0] m_fc(longint tt);
    return 8'((tt / F) % 256);
  endfunction

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (reset_n) t = t + 1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (5) @(posedge vga_clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dx[k] !== 10'd0 || dy[k] !== 10'd0 || bl[k] !== 1'b0 || hs[k] !== 1'b1 ||
          vs[k] !== 1'b1 || fs[k] !== 1'b0 || fc[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: got x=%0d y=%0d blank=%b hs=%b vs=%b fs=%b fc=%0d, need 0 0 0 1 1 0 0",
                 k, dx[k], dy[k], bl[k], hs[k], vs[k], fs[k], fc[k]);
      end
    end
    @(negedge vga_clk);
    reset_n = 1'b1;
    t = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dx[k] !== 10'd1 || dy[k] !== 10'd0 || bl[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL first_edge dut%0d: got x=%0d y=%0d blank=%b, need x=1 y=0 blank=1",
                 k, dx[k], dy[k], bl[k]);
      end
    end
  endtask

  task automatic test_blank();
    int ones = 0;
    for (int i = 0; i < F; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (dx[k] !== 10'(mx(t)) || dy[k] !== 10'(my(t)) || bl[k] !== m_blank(t)) begin
          n_fail++;
          $display("FAIL blank dut%0d t=%0d: got x=%0d y=%0d blank=%b, need x=%0d y=%0d blank=%b",
                   k, t, dx[k], dy[k], bl[k], mx(t), my(t), m_blank(t));
        end
      end
      if (bl[1] === 1'b1) ones++;
    end
    n_tests++;
    if (ones != HV * VV) begin
      n_fail++;
      $display("FAIL blank_count: got %0d visible clocks per frame, need %0d", ones, HV * VV);
    end
  endtask

  task automatic test_sync();
    int   hs_low = 0;
    int   vs_low = 0;
    logic prev [3];
    for (int k = 0; k < 3; k++) prev[k] = hs[k];
    for (int i = 0; i < F; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (hs[k] !== m_hs(t, dly(k)) || vs[k] !== m_vs(t, dly(k))) begin
          n_fail++;
          $display("FAIL sync dut%0d t=%0d: got hs=%b vs=%b, need hs=%b vs=%b",
                   k, t, hs[k], vs[k], m_hs(t, dly(k)), m_vs(t, dly(k)));
        end
        if (prev[k] === 1'b1 && hs[k] === 1'b0) begin
          n_tests++;
          if (dx[k] !== 10'(HV + HFP + dly(k))) begin
            n_fail++;
            $display("FAIL hs_first_low dut%0d: got DrawX=%0d, need %0d",
                     k, dx[k], HV + HFP + dly(k));
          end
        end
        prev[k] = hs[k];
      end
      if (hs[1] === 1'b0) hs_low++;
      if (vs[1] === 1'b0) vs_low++;
    end
    n_tests++;
    if (hs_low != HS * VT) begin
      n_fail++;
      $display("FAIL hs_low_count: got %0d, need %0d", hs_low, HS * VT);
    end
    n_tests++;
    if (vs_low != VS * HT) begin
      n_fail++;
      $display("FAIL vs_low_count: got %0d, need %0d", vs_low, VS * HT);
    end
  endtask

  task automatic test_frame_wrap();
    int last   = -1;
    int pulses = 0;
    for (int i = 0; i < 2 * F; i++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (fs[k] !== m_fs(t) || fc[k] !== m_fc(t)) begin
          n_fail++;
          $display("FAIL frame dut%0d t=%0d: got fs=%b fc=%0d, need fs=%b fc=%0d",
                   k, t, fs[k], fc[k], m_fs(t), m_fc(t));
        end
      end
      if (fs[1] === 1'b1) begin
        pulses++;
        n_tests++;
        if (dx[1] !== 10'd0 || dy[1] !== 10'd0) begin
          n_fail++;
          $display("FAIL fs_position: got x=%0d y=%0d, need 0 0", dx[1], dy[1]);
        end
        if (last >= 0) begin
          n_tests++;
          if (i - last != F) begin
            n_fail++;
            $display("FAIL fs_interval: got %0d, need %0d", i - last, F);
          end
        end
        last = i;
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL fs_pulses: got %0d in %0d clocks, need 2", pulses, 2 * F);
    end
  endtask

  task automatic test_frame_count_wrap();
    while (t < longint'(256 * F)) begin
      tick();
      if (m_fs(t)) begin
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (fc[k] !== m_fc(t)) begin
            n_fail++;
            $display("FAIL frame_count dut%0d t=%0d: got %0d, need %0d", k, t, fc[k], m_fc(t));
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (fc[k] !== 8'd0 || fs[k] !== 1'b1) begin
        n_fail++;
        $display("FAIL fc_wrap256 dut%0d: got fc=%0d fs=%b, need fc=0 fs=1", k, fc[k], fs[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int target = (VV + VFP) * HT + HV + HFP + 1;  // inside both syncs
    for (int i = 0; i < F && int'(t % F) != target; i++) tick();
    n_tests++;
    if (int'(t % F) != target || hs[1] !== 1'b0 || vs[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_setup: got pos=%0d hs=%b vs=%b, need pos=%0d hs=0 vs=0",
               t % F, hs[1], vs[1], target);
    end
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dx[k] !== 10'd0 || dy[k] !== 10'd0 || bl[k] !== 1'b0 || hs[k] !== 1'b1 ||
          vs[k] !== 1'b1 || fs[k] !== 1'b0 || fc[k] !== 8'd0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: got x=%0d y=%0d blank=%b hs=%b vs=%b fc=%0d, need 0 0 0 1 1 0",
                 k, dx[k], dy[k], bl[k], hs[k], vs[k], fc[k]);
      end
    end
    tick();
    @(negedge vga_clk);
    reset_n = 1'b1;
    t = 0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (dx[k] !== 10'd1 || dy[k] !== 10'd0 || bl[k] !== 1'b1 || hs[k] !== m_hs(t, dly(k))) begin
        n_fail++;
        $display("FAIL restart dut%0d: got x=%0d y=%0d blank=%b hs=%b, need 1 0 1 %b",
                 k, dx[k], dy[k], bl[k], hs[k], m_hs(t, dly(k)));
      end
    end
  endtask

  task automatic test_random_reset();
    for (int it = 0; it < 6; it++) begin
      int n = int'($urandom_range(1, 3 * F));
      for (int i = 0; i < n; i++) begin
        tick();
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (dx[k] !== 10'(mx(t)) || dy[k] !== 10'(my(t)) || bl[k] !== m_blank(t) ||
              hs[k] !== m_hs(t, dly(k)) || vs[k] !== m_vs(t, dly(k)) ||
              fs[k] !== m_fs(t) || fc[k] !== m_fc(t)) begin
            n_fail++;
            $display("FAIL random dut%0d t=%0d: got x=%0d y=%0d b=%b hs=%b vs=%b fs=%b fc=%0d, need %0d %0d %b %b %b %b %0d",
                     k, t, dx[k], dy[k], bl[k], hs[k], vs[k], fs[k], fc[k], mx(t), my(t),
                     m_blank(t), m_hs(t, dly(k)), m_vs(t, dly(k)), m_fs(t), m_fc(t));
          end
        end
      end
      #($urandom_range(1, 3)) reset_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (dx[k] !== 10'd0 || hs[k] !== 1'b1 || vs[k] !== 1'b1 || fc[k] !== 8'd0) begin
          n_fail++;
          $display("FAIL random_reset dut%0d: got x=%0d hs=%b vs=%b fc=%0d, need 0 1 1 0",
                   k, dx[k], hs[k], vs[k], fc[k]);
        end
      end
      repeat ($urandom_range(1, 3)) tick();
      @(negedge vga_clk);
      reset_n = 1'b1;
      t = 0;
    end
  endtask

  initial begin
    test_reset();
    test_blank();
    test_sync();
    test_frame_wrap();
    test_frame_count_wrap();
    test_mid_reset();
    test_random_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
